// File: rtl/cordic_iter_fsm_pkg.sv
// Shared constants and state encoding for the CORDIC iteration controller.
// The SCALE encoding exists only when CORDIC_SCALE_EN is defined.
package cordic_iter_fsm_pkg;

  localparam int CNT_W_DEF  = 5;
  localparam int N_ITER_DEF = 25;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
`ifdef CORDIC_SCALE_EN
    S_SCALE = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_iter_fsm.sv
// Moore iteration controller for the CORDIC datapath: load, N_ITER micro-rotations,
// optional gain scaling (CORDIC_SCALE_EN), then a done/ack handshake.
module cordic_iter_fsm
  import cordic_iter_fsm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_fsm,
  input  logic [CNT_W-1:0] iter_cnt,
  input  logic             ack_out,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic             load_init,
  output logic             enab_iter,
  output logic             scale_en,
  output logic             ready,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ITER - 1);

  state_t state, state_nxt;
  logic   iter_last;

  // >= rather than == so a stray count past the end still terminates the loop
  assign iter_last = (iter_cnt >= LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    unique case (state)
      S_IDLE:  state_nxt = beg_fsm ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_ITER;
`ifdef CORDIC_SCALE_EN
      S_ITER:  state_nxt = iter_last ? S_SCALE : S_ITER;
      S_SCALE: state_nxt = S_DONE;
`else
      S_ITER:  state_nxt = iter_last ? S_DONE : S_ITER;
`endif
      S_DONE:  state_nxt = ack_out ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_rst   = 1'b0;
    cnt_en    = 1'b0;
    load_init = 1'b0;
    enab_iter = 1'b0;
    scale_en  = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready   = 1'b1;
        cnt_rst = 1'b1;
      end
      S_LOAD: begin
        load_init = 1'b1;
        cnt_rst   = 1'b1;
      end
      S_ITER: begin
        enab_iter = 1'b1;
        cnt_en    = 1'b1;
      end
`ifdef CORDIC_SCALE_EN
      S_SCALE: begin
        scale_en = 1'b1;
        cnt_rst  = 1'b1;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cnt_rst = 1'b1;
      end
      default: begin
        cnt_rst = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cordic_iter_fsm.sv
// Bench for cordic_iter_fsm: two instances (25 iterations on a 5-bit counter, 8 on a
// 3-bit counter) each driven by a simple up-counter, checked against cycle-offset expectations.
module tb_cordic_iter_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_beg, a_ack, b_beg, b_ack;
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;
  logic a_cnt_rst, a_cnt_en, a_load, a_iter, a_scale, a_ready, a_done;
  logic b_cnt_rst, b_cnt_en, b_load, b_iter, b_scale, b_ready, b_done;

  cordic_iter_fsm #(.CNT_W(5), .N_ITER(25)) dut_a (
    .clk(clk), .rst(rst), .beg_fsm(a_beg), .iter_cnt(a_cnt), .ack_out(a_ack),
    .cnt_rst(a_cnt_rst), .cnt_en(a_cnt_en), .load_init(a_load), .enab_iter(a_iter),
    .scale_en(a_scale), .ready(a_ready), .done(a_done)
  );

  cordic_iter_fsm #(.CNT_W(3), .N_ITER(8)) dut_b (
    .clk(clk), .rst(rst), .beg_fsm(b_beg), .iter_cnt(b_cnt), .ack_out(b_ack),
    .cnt_rst(b_cnt_rst), .cnt_en(b_cnt_en), .load_init(b_load), .enab_iter(b_iter),
    .scale_en(b_scale), .ready(b_ready), .done(b_done)
  );

  // iteration up-counters as the parent would wire them
  always_ff @(posedge clk) begin
    if (a_cnt_rst)     a_cnt <= 5'd0;
    else if (a_cnt_en) a_cnt <= a_cnt + 5'd1;
    if (b_cnt_rst)     b_cnt <= 3'd0;
    else if (b_cnt_en) b_cnt <= b_cnt + 3'd1;
  end

`ifdef CORDIC_SCALE_EN
  localparam bit HAS_SCALE = 1'b1;
`else
  localparam bit HAS_SCALE = 1'b0;
`endif

  // {ready, cnt_rst, cnt_en, load_init, enab_iter, scale_en, done}
  localparam logic [6:0] V_IDLE  = 7'b1100000;
  localparam logic [6:0] V_LOAD  = 7'b0101000;
  localparam logic [6:0] V_ITER  = 7'b0010100;
  localparam logic [6:0] V_SCALE = 7'b0100010;
  localparam logic [6:0] V_DONE  = 7'b0100001;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [6:0] vec(input bit b);
    if (b) return {b_ready, b_cnt_rst, b_cnt_en, b_load, b_iter, b_scale, b_done};
    return {a_ready, a_cnt_rst, a_cnt_en, a_load, a_iter, a_scale, a_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input bit b, input logic [6:0] exp);
    logic [6:0] got;
    got = vec(b);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s inst=%0d: got %b expected %b", tag, b, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input bit b, input int exp);
    logic [31:0] got;
    got = b ? {29'b0, b_cnt} : {27'b0, a_cnt};
    n_tests++;
    assert (got === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s inst=%0d: got %0d expected %0d", tag, b, got, exp);
    end
  endtask

  task automatic set_beg(input bit b, input logic v);
    if (b) b_beg = v; else a_beg = v;
  endtask

  task automatic set_ack(input bit b, input logic v);
    if (b) b_ack = v; else a_ack = v;
  endtask

  // One full operation starting from IDLE; returns one cycle after the ack edge (in IDLE).
  task automatic run_op(input bit b, input int n_iter, input int ack_dly,
                        input bit hold_beg, input bit ack_with_beg);
    int w;
    w = b ? 3 : 5;
    set_beg(b, 1'b1);
    step();
    check_vec("load", b, V_LOAD);
    if (!hold_beg) set_beg(b, 1'b0);
    for (int i = 0; i < n_iter; i++) begin
      set_ack(b, 1'($urandom_range(0, 1)));
      step();
      check_vec("iter", b, V_ITER);
      check_cnt("iter_cnt", b, i);
    end
    set_ack(b, 1'b0);
    if (HAS_SCALE) begin
      step();
      check_vec("scale", b, V_SCALE);
    end
    step();
    check_vec("done_first", b, V_DONE);
    check_cnt("cnt_at_done", b, HAS_SCALE ? 0 : (n_iter % (1 << w)));
    for (int d = 0; d < ack_dly; d++) begin
      if (!hold_beg) set_beg(b, 1'($urandom_range(0, 1)));
      step();
      check_vec("done_hold", b, V_DONE);
    end
    set_ack(b, 1'b1);
    if (ack_with_beg) set_beg(b, 1'b1);
    else if (!hold_beg) set_beg(b, 1'b0);
    step();
    check_vec("ack_to_idle", b, V_IDLE);
    set_ack(b, 1'b0);
    if (ack_with_beg) begin
      set_beg(b, 1'b0);
      step();
      check_vec("no_queued_start", b, V_IDLE);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_beg = 1'b0; a_ack = 1'b0; b_beg = 1'b0; b_ack = 1'b0;
    repeat (3) step();
    check_vec("reset_idle", 1'b0, V_IDLE);
    check_vec("reset_idle", 1'b1, V_IDLE);
    rst = 1'b1;
    step();
    check_vec("post_reset", 1'b0, V_IDLE);
    check_cnt("post_reset_cnt", 1'b0, 0);
    check_cnt("post_reset_cnt", 1'b1, 0);

    // basic operation, prompt ack
    run_op(1'b0, 25, 0, 1'b0, 1'b0);
    // slow ack, then ack together with beg
    run_op(1'b0, 25, 10, 1'b0, 1'b1);

    // beg held high: one operation per IDLE visit
    a_beg = 1'b1;
    step();
    check_vec("held_beg_load", 1'b0, V_LOAD);
    // back off one cycle: the above step consumed the start edge, so re-enter via IDLE
    a_beg = 1'b0;
    for (int i = 0; i < 25; i++) step();
    if (HAS_SCALE) step();
    step();
    check_vec("held_beg_pre_done", 1'b0, V_DONE);
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    check_vec("held_beg_pre_idle", 1'b0, V_IDLE);
    a_beg = 1'b1;
    run_op(1'b0, 25, 2, 1'b1, 1'b0);
    run_op(1'b0, 25, 1, 1'b1, 1'b0);
    a_beg = 1'b0;
    step();
    check_vec("held_beg_release", 1'b0, V_IDLE);

    // synchronous reset in the 7th ITER cycle
    a_beg = 1'b1;
    step();
    check_vec("rst_load", 1'b0, V_LOAD);
    a_beg = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_vec("rst_iter7", 1'b0, V_ITER);
    check_cnt("rst_iter7_cnt", 1'b0, 6);
    rst = 1'b0;
    step();
    check_vec("rst_mid_iter", 1'b0, V_IDLE);
    rst = 1'b1;
    step();
    check_vec("rst_after", 1'b0, V_IDLE);
    check_cnt("rst_cnt_clear", 1'b0, 0);

    // full-range counter: N_ITER = 2**CNT_W
    run_op(1'b1, 8, 0, 1'b0, 1'b0);
    run_op(1'b1, 8, 3, 1'b0, 1'b1);

    // randomized mix of idle gaps, ack delays and instances
    for (int r = 0; r < 6; r++) begin
      bit sel;
      int gap;
      sel = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        check_vec("idle_gap", sel, V_IDLE);
      end
      run_op(sel, sel ? 8 : 25, $urandom_range(0, 5), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
